road_scroll_drawer: RTL and testbench

- Upstream pixel source for the 160x120, 3-bit-colour VGA adapter.
- Produces the adapter's x / y / colour / plot stream so that dashed lane markers appear to scroll down the screen.
- On every frame tick it rewrites the full height of each marker column strip with dash or road colour, then advances a scroll offset by a switch-selected speed.
- The background image, including road and grass, stays in adapter memory. Only the marker columns are rewritten.

---
 rtl/road_scroll_drawer_pkg.sv | 19 +
 rtl/road_scroll_drawer_if.sv | 14 +
 rtl/road_scroll_drawer_tick_gen.sv | 44 ++++
 rtl/road_scroll_drawer.sv | 176 +++++++++++++++++
 tb/tb_road_scroll_drawer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/road_scroll_drawer_pkg.sv
// Shared constants and types for the road scroll drawer and its sibling
// movers that also feed the 160x120 3-bit-colour VGA adapter.
package road_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOUR_W = 3;

  // Adapter coordinate widths: 0..159 fits in 8 bits, 0..119 in 7 bits.
  localparam int X_W = 8;
  localparam int Y_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    ADVANCE
  } state_e;

endpackage

// File: rtl/road_scroll_drawer_if.sv
// Pixel stream toward the VGA adapter, plus the redraw-in-progress flag.
interface road_scroll_drawer_if;
  import road_pkg::*;

  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                busy;

  modport master (output x, y, colour, plot, busy);
  modport slave  (input  x, y, colour, plot, busy);

endinterface

// File: rtl/road_scroll_drawer_tick_gen.sv
// Free-running frame tick: one-cycle pulse every TICK_DIV clocks, the first
// one TICK_DIV clocks after reset release.
module tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic clock,
  input  logic resetn,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Down-count and reload; the pulse is raised on the reload cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else can leave a value held and infer a latch.
    cnt_d  = cnt_q - 1'b1;
    tick_d = 1'b0;
    if (cnt_q == '0) begin
      cnt_d  = RELOAD;
      tick_d = 1'b1;
    end
  end

  // Counter and registered pulse.
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!resetn) begin
      cnt_q  <= RELOAD;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/road_scroll_drawer.sv
// Redraws the dashed lane-marker columns once per frame tick, one pixel per
// clock, then advances the scroll offset so the dashes move down the screen.
module road_scroll_drawer
  import road_pkg::*;
#(
  parameter int                  TICK_DIV    = 833333,
  parameter int                  MARK_X0     = 53,
  parameter int                  MARK_X1     = 106,
  parameter int                  MARK_W      = 2,
  parameter int                  DASH_PERIOD = 16,
  parameter int                  DASH_LEN    = 8,
  parameter logic [COLOUR_W-1:0] DASH_COLOUR = 3'b111,
  parameter logic [COLOUR_W-1:0] ROAD_COLOUR = 3'b000
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       enable,
  input  logic [1:0]                 speed,
  road_scroll_drawer_if.master       pix
);

  localparam int OFS_W = $clog2(DASH_PERIOD);
  localparam int COL_W = 2;

  typedef logic [OFS_W-1:0] ofs_t;

  localparam ofs_t             PHASE_LAST = ofs_t'(DASH_PERIOD - 1);
  localparam ofs_t             DASH_LEN_T = ofs_t'(DASH_LEN);
  localparam logic [OFS_W:0]   PERIOD_EXT = (OFS_W + 1)'(DASH_PERIOD);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(MARK_W - 1);
  localparam logic [Y_W-1:0]   ROW_LAST   = Y_W'(SCREEN_H - 1);

  state_e              state_q;
  ofs_t                offset_q;
  logic                pending_q;
  logic [Y_W-1:0]      row_q;
  logic                line_q;
  logic [COL_W-1:0]    col_q;
  ofs_t                phase_q;
  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;
  logic [COLOUR_W-1:0] colour_q;
  logic                plot_q;
  logic                busy_q;

  logic                tick;
  logic                tick_en;
  logic                frame_req;
  logic                last_pixel;
  logic [Y_W-1:0]      nxt_row;
  logic                nxt_line;
  logic [COL_W-1:0]    nxt_col;
  ofs_t                nxt_phase;
  ofs_t                start_phase;
  ofs_t                offset_adv;
  logic [OFS_W:0]      ofs_sum;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clock  (clock),
    .resetn (resetn),
    .tick   (tick)
  );

  assign tick_en    = tick & enable;
  assign frame_req  = tick_en | pending_q;
  assign last_pixel = (row_q == ROW_LAST) && line_q && (col_q == COL_LAST);

  function automatic logic [X_W-1:0] pixel_x(input logic line, input logic [COL_W-1:0] col);
    return (line ? X_W'(MARK_X1) : X_W'(MARK_X0)) + X_W'(col);
  endfunction

  function automatic logic [COLOUR_W-1:0] pixel_colour(input ofs_t phase);
    return (phase < DASH_LEN_T) ? DASH_COLOUR : ROAD_COLOUR;
  endfunction

  // Scan position of the pixel after the current one: col, then line, then
  // row; phase wraps with the row so no modulo is needed.
  always_comb begin
    nxt_col   = col_q + 1'b1;
    nxt_line  = line_q;
    nxt_row   = row_q;
    nxt_phase = phase_q;
    if (col_q == COL_LAST) begin
      nxt_col = '0;
      if (line_q) begin
        nxt_line  = 1'b0;
        nxt_row   = row_q + 1'b1;
        nxt_phase = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
      end else begin
        nxt_line = 1'b1;
      end
    end
  end

  // Offset arithmetic: start phase for row 0 and the wrapped post-frame offset.
  always_comb begin
    ofs_sum    = {1'b0, offset_q} + {{(OFS_W - 1){1'b0}}, speed};
    offset_adv = ofs_t'(ofs_sum);
    if (ofs_sum >= PERIOD_EXT) begin
      offset_adv = ofs_t'(ofs_sum - PERIOD_EXT);
    end
    start_phase = '0;
    if (offset_q != '0) begin
      start_phase = ofs_t'(PERIOD_EXT - {1'b0, offset_q});
    end
  end

  // Frame FSM with registered pixel outputs; reset aborts any frame in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      offset_q  <= '0;
      pending_q <= 1'b0;
      row_q     <= '0;
      line_q    <= 1'b0;
      col_q     <= '0;
      phase_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_req) begin
            state_q   <= DRAW;
            pending_q <= 1'b0;
            row_q     <= '0;
            line_q    <= 1'b0;
            col_q     <= '0;
            phase_q   <= start_phase;
            x_q       <= pixel_x(1'b0, '0);
            y_q       <= '0;
            colour_q  <= pixel_colour(start_phase);
            plot_q    <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        DRAW: begin
          if (tick_en) pending_q <= 1'b1;
          if (last_pixel) begin
            state_q <= ADVANCE;
            plot_q  <= 1'b0;
          end else begin
            row_q    <= nxt_row;
            line_q   <= nxt_line;
            col_q    <= nxt_col;
            phase_q  <= nxt_phase;
            x_q      <= pixel_x(nxt_line, nxt_col);
            y_q      <= nxt_row;
            colour_q <= pixel_colour(nxt_phase);
          end
        end
        ADVANCE: begin
          if (tick_en) pending_q <= 1'b1;
          offset_q <= offset_adv;
          state_q  <= IDLE;
          busy_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          plot_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pix.x      = x_q;
  assign pix.y      = y_q;
  assign pix.colour = colour_q;
  assign pix.plot   = plot_q;
  assign pix.busy   = busy_q;

endmodule

// File: tb/tb_road_scroll_drawer.sv
// Bench for road_scroll_drawer: two instances (a slow tick that never
// overruns, and a fast tick with wide markers that always overruns) checked
// every cycle against a pixel-index model, plus literal frame expectations.
module tb_road_scroll_drawer;
  import road_pkg::*;

  localparam int TD_A = 400;
  localparam int TD_B = 200;
  localparam int W_A  = 1;
  localparam int W_B  = 2;
  localparam int P    = 16;
  localparam int L    = 8;
  localparam int X0   = 53;
  localparam int X1   = 106;
  localparam int N_A  = 240 * W_A;
  localparam int N_B  = 240 * W_B;
  localparam int DASH = 7;
  localparam int ROAD = 0;

  logic       clk    = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] speed  = 2'd0;

  always #5 clk = ~clk;

  road_scroll_drawer_if if_a();
  road_scroll_drawer_if if_b();

  road_scroll_drawer #(.TICK_DIV(TD_A), .MARK_W(W_A)) dut_a (
    .clock(clk), .resetn(resetn), .enable(enable), .speed(speed), .pix(if_a)
  );

  road_scroll_drawer #(.TICK_DIV(TD_B), .MARK_W(W_B)) dut_b (
    .clock(clk), .resetn(resetn), .enable(enable), .speed(speed), .pix(if_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_pos: -1 idle, 0..N-1 index of the pixel on the bus, N = post-frame cycle.
  int m_n;
  int m_pos[2];
  int m_off[2];
  bit m_pend[2];

  function automatic int td(input int i);
    return (i == 0) ? TD_A : TD_B;
  endfunction

  function automatic int nw(input int i);
    return (i == 0) ? W_A : W_B;
  endfunction

  task automatic model_reset();
    m_n = 0;
    for (int i = 0; i < 2; i++) begin
      m_pos[i]  = -1;
      m_off[i]  = 0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit t;
    m_n++;
    for (int i = 0; i < 2; i++) begin
      t = enable && (m_n > td(i)) && (((m_n - 1) % td(i)) == 0);
      if (m_pos[i] < 0) begin
        if (t || m_pend[i]) begin
          m_pend[i] = 1'b0;
          m_pos[i]  = 0;
        end
      end else begin
        if (t) m_pend[i] = 1'b1;
        if (m_pos[i] == 240 * nw(i)) begin
          m_off[i] = (m_off[i] + int'(speed)) % P;
          m_pos[i] = -1;
        end else begin
          m_pos[i]++;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) model_reset();
      else model_step();
    end
  end

  task automatic cmp(input int i, input logic plot, input logic busy,
                     input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    int p, w, row, line, col, ph;
    bit exp_plot;
    p = m_pos[i];
    w = nw(i);
    exp_plot = (p >= 0) && (p < 240 * w);
    check(i == 0 ? "a_plot" : "b_plot", plot, exp_plot);
    check(i == 0 ? "a_busy" : "b_busy", busy, p >= 0);
    if (exp_plot) begin
      row  = p / (2 * w);
      line = (p / w) % 2;
      col  = p % w;
      ph   = (((row - m_off[i]) % P) + P) % P;
      check(i == 0 ? "a_x" : "b_x", x, (line != 0 ? X1 : X0) + col);
      check(i == 0 ? "a_y" : "b_y", y, row);
      check(i == 0 ? "a_colour" : "b_colour", c, (ph < L) ? DASH : ROAD);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      cmp(0, if_a.plot, if_a.busy, if_a.x, if_a.y, if_a.colour);
      cmp(1, if_b.plot, if_b.busy, if_b.x, if_b.y, if_b.colour);
    end
  end

  // ---------------- frame monitors ----------------
  logic [2:0] img_cur[2][120];
  logic [2:0] img_last[2][120];
  logic [2:0] img_f1[2][120];
  int run_a = 0, frames_a = 0;
  bit prev_a = 1'b0;

  always @(negedge clk) begin
    if (!resetn) begin
      run_a  = 0;
      prev_a = 1'b0;
    end else begin
      if (if_a.plot) begin
        if (if_a.y < 7'd120) begin
          if (if_a.x == 8'(X1)) img_cur[1][if_a.y] = if_a.colour;
          else img_cur[0][if_a.y] = if_a.colour;
        end
        run_a++;
      end else if (prev_a) begin
        check("a_frame_len", run_a, N_A);
        img_last = img_cur;
        frames_a++;
        run_a = 0;
      end
      prev_a = if_a.plot;
    end
  end

  int run_b = 0, gap_b = 0, min_gap_b = 1000;
  bit prev_b = 1'b0, gap_ok = 1'b0;

  always @(negedge clk) begin
    if (!resetn) begin
      run_b  = 0;
      prev_b = 1'b0;
      gap_ok = 1'b0;
    end else begin
      if (if_b.plot) begin
        if (!prev_b && gap_ok && gap_b < min_gap_b) min_gap_b = gap_b;
        run_b++;
      end else if (prev_b) begin
        check("b_frame_len", run_b, N_B);
        run_b  = 0;
        gap_b  = 1;
        gap_ok = 1'b1;
      end else if (gap_ok) begin
        gap_b++;
      end
      prev_b = if_b.plot;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_frame_end_a(input int budget);
    int f0;
    f0 = frames_a;
    for (int k = 0; k < budget && frames_a == f0; k++) step();
    check("a_frame_end_seen", frames_a != f0, 1'b1);
  endtask

  task automatic wait_plot_a(input int budget);
    for (int k = 0; k < budget && !if_a.plot; k++) step();
    check("a_plot_seen", if_a.plot, 1'b1);
  endtask

  initial begin
    int diffs;
    int pause_plots;

    speed  = 2'd1;
    enable = 1'b1;
    #3;
    check("rst_a_x", if_a.x, 0);
    check("rst_a_y", if_a.y, 0);
    check("rst_a_colour", if_a.colour, 0);
    check("rst_a_plot", if_a.plot, 0);
    check("rst_a_busy", if_a.busy, 0);
    check("rst_b_plot", if_b.plot, 0);
    check("rst_b_busy", if_b.busy, 0);
    repeat (2) step();
    resetn = 1'b1;

    // Frame 1 at offset 0; now in its post-frame cycle.
    wait_frame_end_a(TD_A + 300);
    check("f1_x53_y0", img_last[0][0], DASH);
    check("f1_x106_y8", img_last[1][8], ROAD);
    check("f1_x53_y16", img_last[0][16], DASH);
    check("f1_busy_after_last", if_a.busy, 1'b1);
    img_f1 = img_last;
    step();
    check("f1_busy_fall", if_a.busy, 1'b0);

    // Frame 2 at offset 1.
    wait_frame_end_a(TD_A + 300);
    check("f2_y0", img_last[0][0], ROAD);
    check("f2_y1", img_last[0][1], DASH);
    check("f2_y8", img_last[0][8], DASH);
    check("f2_y9", img_last[0][9], ROAD);

    // Frames 3..17; sixteen advances of 1 bring the offset back to 0.
    repeat (15) wait_frame_end_a(TD_A + 300);
    diffs = 0;
    for (int ln = 0; ln < 2; ln++)
      for (int r = 0; r < 120; r++)
        if (img_last[ln][r] !== img_f1[ln][r]) diffs++;
    check("wrap_equal", diffs, 0);

    // Speed 3: offsets 3, 6, 9, 12, 15, 2 on frames 18..23.
    speed = 2'd3;
    repeat (6) wait_frame_end_a(TD_A + 300);
    check("f23_y1", img_last[0][1], ROAD);
    check("f23_y2", img_last[0][2], DASH);
    check("f23_y9", img_last[1][9], DASH);
    check("f23_y10", img_last[1][10], ROAD);

    // Pause before the next tick.
    enable = 1'b0;
    pause_plots = 0;
    repeat (3 * TD_A) begin
      step();
      if (if_a.plot) pause_plots++;
    end
    check("pause_plots", pause_plots, 0);

    // Enable dropped mid-frame: the frame still completes.
    enable = 1'b1;
    wait_plot_a(2 * TD_A);
    repeat (100) step();
    enable = 1'b0;
    wait_frame_end_a(400);
    enable = 1'b1;

    // Reset at pixel 100 of a frame.
    wait_plot_a(2 * TD_A);
    repeat (100) step();
    #1 resetn = 1'b0;
    #1;
    check("abort_a_plot", if_a.plot, 1'b0);
    check("abort_a_busy", if_a.busy, 1'b0);
    check("abort_b_busy", if_b.busy, 1'b0);
    repeat (3) step();
    resetn = 1'b1;
    wait_plot_a(TD_A + 20);
    check("restart_x", if_a.x, X0);
    check("restart_y", if_a.y, 0);
    check("restart_colour", if_a.colour, DASH);

    // Randomised speed / enable.
    repeat (16) begin
      speed  = 2'($urandom_range(0, 3));
      enable = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(50, 700)) step();
    end
    enable = 1'b1;
    repeat (600) step();

    check("b_min_gap", min_gap_b, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
